// File: rtl/svc_rv_demo_status_pkg.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_demo_status_pkg
// Purpose  : Shared types for the RISC-V demo run-status indicator.
//            Defines the 2-bit program lifecycle state encoding.
// Revision : 1.0  initial release
// ============================================================================
package svc_rv_demo_status_pkg;

    // Program lifecycle. DONE and FAULT are terminal until reset.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Width of the brightness PWM counter (duty is expressed out of 256).
    localparam int unsigned c_pwm_width = 8;

endpackage : svc_rv_demo_status_pkg
`default_nettype wire

// File: rtl/svc_rv_demo_status_div.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_demo_status_div
// Purpose  : Free-running wrap-around counter. Used as the heartbeat/fault
//            blink divider and, when PWM dimming is built in, as the PWM
//            phase counter.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset, clears the count
//            count  - current counter value (WIDTH bits)
// Revision : 1.0  initial release
// ============================================================================
module svc_rv_demo_status_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : svc_rv_demo_status_div
`default_nettype wire

// File: rtl/svc_rv_demo_status.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_demo_status
// Purpose  : Run-status indicator between a RISC-V SoC and the board LEDs.
//            Tracks IDLE -> RUN -> DONE (ebreak) / FAULT (trap), counts the
//            cycles spent running (saturating) and drives the LED bank:
//              IDLE  : all off
//              RUN   : LED0 heartbeat from the divider MSB
//              DONE  : LED0 on, upper LEDs show run-length MSBs
//              FAULT : all LEDs blink together
// Config   : define SVC_RV_DEMO_STATUS_PWM_EN to dim DONE-state LEDs with an
//            8-bit PWM (duty BRIGHTNESS/256). Default build has no PWM.
// Ports    : clk     - system clock
//            rst_n   - asynchronous active-low reset
//            en      - level start request, sampled in IDLE only
//            ebreak  - SoC ebreak indication (RUN -> DONE)
//            trap    - SoC trap indication (RUN -> FAULT, wins over ebreak)
//            leds    - LED drive, 1 = on
//            done    - sticky, program ended via ebreak
//            fault   - sticky, program ended via trap
//            cycles  - saturating count of cycles spent in RUN
// Revision : 1.0  initial release
// ============================================================================
module svc_rv_demo_status
    import svc_rv_demo_status_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int CYCLE_CNT_W    = 32,
    parameter int HB_DIV_BITS    = 24,
    parameter int FAULT_DIV_BITS = 21,
    parameter int BRIGHTNESS     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   ebreak,
    input  logic                   trap,
    output logic [NUM_LEDS-1:0]    leds,
    output logic                   done,
    output logic                   fault,
    output logic [CYCLE_CNT_W-1:0] cycles
);

    localparam logic [CYCLE_CNT_W-1:0] c_cycles_max = {CYCLE_CNT_W{1'b1}};

    state_t                   r_state;
    logic [CYCLE_CNT_W-1:0]   r_cycles;
    logic [HB_DIV_BITS-1:0]   w_div;
    logic [NUM_LEDS-1:0]      w_done_leds;
    logic [NUM_LEDS-1:0]      w_leds;
    logic                     w_pwm_on;
    logic                     w_unused;

    // ------------------------------------------------------------------
    // Heartbeat / fault blink divider
    // ------------------------------------------------------------------
    svc_rv_demo_status_div #(
        .WIDTH (HB_DIV_BITS)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .count (w_div)
    );

`ifdef SVC_RV_DEMO_STATUS_PWM_EN
    // ------------------------------------------------------------------
    // DONE-state dimming. Compare in 9 bits so BRIGHTNESS=256 is always on.
    // ------------------------------------------------------------------
    localparam logic [c_pwm_width:0] c_brightness = (c_pwm_width + 1)'(BRIGHTNESS);

    logic [c_pwm_width-1:0] w_pwm_cnt;

    svc_rv_demo_status_div #(
        .WIDTH (c_pwm_width)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .count (w_pwm_cnt)
    );

    assign w_pwm_on = ({1'b0, w_pwm_cnt} < c_brightness);
    assign w_unused = &{1'b0, w_div};
`else
    assign w_pwm_on = 1'b1;
    // Only two divider taps feed the LEDs; brightness has no effect here.
    assign w_unused = &{1'b0, w_div, 9'(BRIGHTNESS)};
`endif

    // ------------------------------------------------------------------
    // Lifecycle FSM and saturating run-cycle counter.
    // The exit edge from RUN is itself counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_cycles != c_cycles_max) begin
                        r_cycles <= r_cycles + CYCLE_CNT_W'(1);
                    end
                    if (trap) begin
                        r_state <= ST_FAULT;
                    end else if (ebreak) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    // DONE / FAULT hold until reset
                    r_state <= r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // DONE-state pattern: LED0 solid, upper LEDs show the counter MSBs.
    // ------------------------------------------------------------------
    if (NUM_LEDS > 1) begin : g_done_msbs
        assign w_done_leds = {r_cycles[CYCLE_CNT_W-1 -: NUM_LEDS-1], 1'b1};
    end else begin : g_done_led0
        assign w_done_leds = 1'b1;
    end

    always_comb begin
        w_leds = '0;
        case (r_state)
            ST_RUN:   w_leds[0] = w_div[HB_DIV_BITS-1];
            ST_DONE:  w_leds    = w_done_leds & {NUM_LEDS{w_pwm_on}};
            ST_FAULT: w_leds    = {NUM_LEDS{w_div[FAULT_DIV_BITS-1]}};
            default:  w_leds    = '0;
        endcase
    end

    assign leds   = w_leds;
    assign done   = (r_state == ST_DONE);
    assign fault  = (r_state == ST_FAULT);
    assign cycles = r_cycles;

endmodule : svc_rv_demo_status
`default_nettype wire

// File: tb/tb_svc_rv_demo_status.sv
`default_nettype none
// ============================================================================
// Module   : tb_svc_rv_demo_status
// Purpose  : Self-checking bench for svc_rv_demo_status. A behavioural model
//            predicts outputs after each clock edge; predictions are queued
//            and compared against the DUT shortly after the edge.
//            Honours SVC_RV_DEMO_STATUS_PWM_EN for the dimming checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_svc_rv_demo_status;

    localparam int c_num_leds   = 4;
    localparam int c_cnt_w      = 8;
    localparam int c_hb_bits    = 4;
    localparam int c_fault_bits = 2;
    localparam int c_brightness = 64;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;
    localparam int M_FAULT = 3;

    typedef struct packed {
        logic [3:0] leds;
        logic       done;
        logic       fault;
        logic [7:0] cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ebreak;
    logic       trap;
    logic [3:0] leds;
    logic       done;
    logic       fault;
    logic [7:0] cycles;

    int checks = 0;
    int errors = 0;

    int         m_state;
    logic [7:0] m_cycles;
    logic [3:0] m_div;
    logic [7:0] m_pwm;
    exp_t       sb[$];

    always #5 clk = ~clk;

    svc_rv_demo_status #(
        .NUM_LEDS       (c_num_leds),
        .CYCLE_CNT_W    (c_cnt_w),
        .HB_DIV_BITS    (c_hb_bits),
        .FAULT_DIV_BITS (c_fault_bits),
        .BRIGHTNESS     (c_brightness)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .ebreak (ebreak),
        .trap   (trap),
        .leds   (leds),
        .done   (done),
        .fault  (fault),
        .cycles (cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_cycles = '0;
        m_div    = '0;
        m_pwm    = '0;
    endtask

    task automatic model_edge();
        if (rst_n) begin
            case (m_state)
                M_IDLE: if (en) m_state = M_RUN;
                M_RUN: begin
                    if (m_cycles != 8'hFF) m_cycles = m_cycles + 8'd1;
                    if (trap)        m_state = M_FAULT;
                    else if (ebreak) m_state = M_DONE;
                end
                default: ;
            endcase
            m_div = m_div + 4'd1;
            m_pwm = m_pwm + 8'd1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.leds   = 4'b0000;
        e.done   = (m_state == M_DONE);
        e.fault  = (m_state == M_FAULT);
        e.cycles = m_cycles;
        case (m_state)
            M_RUN:   e.leds = {3'b000, m_div[3]};
            M_DONE: begin
                e.leds = {m_cycles[7:5], 1'b1};
`ifdef SVC_RV_DEMO_STATUS_PWM_EN
                if (m_pwm >= 8'd64) e.leds = 4'b0000;
`endif
            end
            M_FAULT: e.leds = {4{m_div[1]}};
            default: e.leds = 4'b0000;
        endcase
        return e;
    endfunction

    // One clock edge: predict, queue, then compare the oldest prediction.
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        sb.push_back(model_out());
        #1;
        e = sb.pop_front();
        chk("leds",   {28'd0, leds},  {28'd0, e.leds});
        chk("done",   {31'd0, done},  {31'd0, e.done});
        chk("fault",  {31'd0, fault}, {31'd0, e.fault});
        chk("cycles", {24'd0, cycles}, {24'd0, e.cycles});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_leds"},   {28'd0, leds},   32'd0);
        chk({tag, "_done"},   {31'd0, done},   32'd0);
        chk({tag, "_fault"},  {31'd0, fault},  32'd0);
        chk({tag, "_cycles"}, {24'd0, cycles}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("rst");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt [4];

        rst_n  = 1'b0;
        en     = 1'b0;
        ebreak = 1'b0;
        trap   = 1'b0;
        model_reset();
        #1;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle, ebreak without en is ignored
        for (int i = 0; i < 20; i++) begin
            ebreak = (i == 4);
            step();
        end
        ebreak = 1'b0;
        check_zero("t1");

        // 2: start, ebreak on the 37th RUN edge
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 36; i++) step();
        ebreak = 1'b1;
        step();
        ebreak = 1'b0;
        chk("t2_cycles", {24'd0, cycles}, 32'h25);
        chk("t2_done",   {31'd0, done},   32'd1);
`ifndef SVC_RV_DEMO_STATUS_PWM_EN
        chk("t2_leds",   {28'd0, leds},   32'b0011);
`endif
        for (int i = 0; i < 6; i++) begin
            ebreak = i[0];
            trap   = ~i[0];
            step();
        end
        ebreak = 1'b0;
        trap   = 1'b0;
        chk("t2_hold_cycles", {24'd0, cycles}, 32'h25);
        chk("t2_hold_fault",  {31'd0, fault},  32'd0);

        // 3: trap and ebreak together -> fault wins
        do_reset();
        en = 1'b1;
        step();
        en     = 1'b0;
        trap   = 1'b1;
        ebreak = 1'b1;
        step();
        trap   = 1'b0;
        ebreak = 1'b0;
        chk("t3_fault", {31'd0, fault}, 32'd1);
        chk("t3_done",  {31'd0, done},  32'd0);
        for (int i = 0; i < 8; i++) step();

        // 4: saturation after 300 RUN cycles
        do_reset();
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 300; i++) step();
        ebreak = 1'b1;
        step();
        ebreak = 1'b0;
        chk("t4_cycles", {24'd0, cycles}, 32'hFF);
        chk("t4_done",   {31'd0, done},   32'd1);
`ifndef SVC_RV_DEMO_STATUS_PWM_EN
        chk("t4_leds",   {28'd0, leds},   32'b1111);
`else
        // 6: each lit LED on for exactly BRIGHTNESS of every 256 cycles
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            for (int k = 0; k < 4; k++) cnt[k] += int'(leds[k]);
        end
        for (int k = 0; k < 4; k++) chk("t6_pwm_duty", cnt[k], c_brightness);
`endif

        // 5: asynchronous reset between edges mid-RUN, then restart
        do_reset();
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t5_pre_cycles", {24'd0, cycles}, 32'd10);
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        model_reset();
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t5_restart_cycles", {24'd0, cycles}, 32'd5);
        trap = 1'b1;
        step();
        trap = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_fault", {31'd0, fault}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_svc_rv_demo_status
`default_nettype wire
